jtag_scan_controller: RTL and testbench
=======================================

JTAG_SCAN_CONTROLLER -- requirements
Module: jtag_scan_controller

Interface
REQ-001 Parameter MAX_LEN, default 32: maximum scan length in bits, range 1..32.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  single clock; each clk cycle is one TCK period; TAP signals change on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_type  in  2  00 IR scan, 01 DR scan, 10 TAP reset, 11 idle run.
- cmd_len  in  6  bit count (scans) or cycle count (idle).
- cmd_data  in  32  shift-in data, LSB first.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed when valid&ready.
- rsp_data  out  32  captured Tdo bits, right-justified.
- Tms  out  1  TAP mode select.
- Tdi  out  1  TAP data in.
- Trst  out  1  TAP reset, active-low.
- Tdo  in  1  TAP data out.
- busy  out  1  sequence in progress.
- tap_state  out  4  tracked IEEE 1149.1 TAP state.

Function
REQ-003 Controller FSM states SHALL be: INIT_RST, IDLE, GOTO_SHIFT, SHIFT, EXIT, RESP.
REQ-004 cmd_ready SHALL be 1 only in IDLE with rsp_valid=0.
REQ-005 A DR scan SHALL drive Tms 1,0,0 (Select-DR, Capture-DR, Shift-DR).
REQ-006 An IR scan SHALL drive Tms 1,1,0,0.
REQ-007 SHIFT SHALL last N cycles: Tdi=cmd_data[i] in cycle i, Tms=0 for i<N-1 and Tms=1 on the last bit.
REQ-008 EXIT SHALL drive Tms 1 (Update) then 0 (Run-Test/Idle); rsp_valid SHALL rise the cycle after.
REQ-009 DR latency SHALL be accept-to-rsp_valid = N+6 cycles; IR latency SHALL be N+7 cycles.
REQ-010 Tdo SHALL be sampled at the rising edge that ends shift cycle i into rsp_data[i]; rsp_data[31:N] SHALL be 0.
REQ-011 cmd_len=0 SHALL cause no TAP activity, with rsp_valid=1 and rsp_data=0 the next cycle.
REQ-012 cmd_len>MAX_LEN SHALL clamp to MAX_LEN.
REQ-013 Type 10 SHALL drive Tms=1 for 5 cycles then Tms=0 for 1 cycle; rsp_data=0.
REQ-014 Type 11 SHALL drive Tms=0 for cmd_len cycles (0 means a response only); rsp_data=0.
REQ-015 rsp_valid and rsp_data SHALL hold while rsp_ready=0; no new command is accepted meanwhile.
REQ-016 Outside the shift phase, Tdi SHALL be 0.
REQ-017 tap_state SHALL update each cycle from Tms via the standard TAP transition table.
REQ-018 busy SHALL be 1 in every state except IDLE.

Reset
REQ-019 While reset=1, outputs SHALL be: Tms=1, Tdi=0, Trst=1, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=1, tap_state=Test-Logic-Reset, FSM=INIT_RST.
REQ-020 After reset release, INIT_RST SHALL run the type-10 sequence and then enter IDLE with no response.
REQ-021 Reset asserted mid-scan SHALL abort the scan immediately; the partial response SHALL be discarded.

Configuration
REQ-022 With JTAG_TRST_PULSE_EN defined, Trst SHALL be 0 during the 5 Tms=1 cycles of every TAP reset sequence, including INIT_RST.
REQ-023 With JTAG_TRST_PULSE_EN undefined, Trst SHALL be a constant 1 and TAP reset SHALL use Tms only.

Structure
REQ-024 JtagGlobalPkg SHALL hold the following:
- TAP state enum (4-bit).
- command-type enum.
- controller FSM enum.
- MAX_LEN default.
- the IR and DR Tms preamble constants.
REQ-025 TAP next-state logic SHALL be a sub-module, jtag_tap_tracker, with inputs Tms and state and output next state.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- DR scan, len=8, data=0xA5, Tdo loopback of Tdi -> Tms 1,0,0,0x7,1,1,0 pattern; rsp_data=0xA5 at accept+14.
- IR scan, len=4, data=0x3, Tdo=1 -> IR preamble 1,1,0,0; rsp_data=0xF at accept+11.
- cmd_len=40 DR scan -> 32 shift cycles; cmd_len=0 -> rsp_data=0 next cycle with Tms constant.
- rsp_ready held 0 for 10 cycles -> rsp stable, cmd_ready=0, second command waits.
- Reset pulse mid-SHIFT -> outputs at reset values the same cycle; INIT_RST gives 5 Tms=1, then tap_state=Run-Test/Idle.
- Build with JTAG_TRST_PULSE_EN, type 10 -> Trst=0 for exactly 5 cycles aligned to Tms=1.

Source files
------------

// File: rtl/JtagGlobalPkg.sv
// Shared types and constants for the JTAG scan controller: TAP state
// encoding (IEEE 1149.1), command types, controller FSM states and the
// Tms preambles that walk the TAP from Run-Test/Idle into a shift state.
package JtagGlobalPkg;

  localparam int MAX_LEN_DEFAULT = 32;

  // Tms=1 cycles in a TAP reset sequence; a single Tms=0 cycle follows.
  localparam int RST_TMS_CYCLES = 5;

  // Tms preambles, bit i is driven in preamble cycle i.
  localparam int         IR_PRE_LEN = 4;
  localparam logic [3:0] IR_TMS_PRE = 4'b0011;  // 1,1,0,0
  localparam int         DR_PRE_LEN = 3;
  localparam logic [3:0] DR_TMS_PRE = 4'b0001;  // 1,0,0

  typedef enum logic [3:0] {
    TAP_EX2DR   = 4'h0,
    TAP_EX1DR   = 4'h1,
    TAP_SHDR    = 4'h2,
    TAP_PAUSEDR = 4'h3,
    TAP_SELIR   = 4'h4,
    TAP_UPDDR   = 4'h5,
    TAP_CAPDR   = 4'h6,
    TAP_SELDR   = 4'h7,
    TAP_EX2IR   = 4'h8,
    TAP_EX1IR   = 4'h9,
    TAP_SHIR    = 4'hA,
    TAP_PAUSEIR = 4'hB,
    TAP_RTI     = 4'hC,
    TAP_UPDIR   = 4'hD,
    TAP_CAPIR   = 4'hE,
    TAP_TLR     = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    CMD_IR       = 2'b00,
    CMD_DR       = 2'b01,
    CMD_TAP_RST  = 2'b10,
    CMD_IDLE_RUN = 2'b11
  } cmd_type_e;

  typedef enum logic [2:0] {
    INIT_RST,
    IDLE,
    GOTO_SHIFT,
    SHIFT,
    EXIT,
    RESP
  } ctrl_state_e;

endpackage

// File: rtl/jtag_tap_tracker.sv
// Combinational IEEE 1149.1 TAP transition table: next TAP state from the
// current state and the Tms value driven during this TCK cycle.
module jtag_tap_tracker
  import JtagGlobalPkg::*;
(
  input  logic       Tms,
  input  logic [3:0] state,
  output logic [3:0] next_state
);

  tap_state_e cur;
  tap_state_e nxt;

  assign cur        = tap_state_e'(state);
  assign next_state = nxt;

  // Standard TAP transition table.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    nxt = TAP_TLR;
    case (cur)
      TAP_TLR:     nxt = Tms ? TAP_TLR   : TAP_RTI;
      TAP_RTI:     nxt = Tms ? TAP_SELDR : TAP_RTI;
      TAP_SELDR:   nxt = Tms ? TAP_SELIR : TAP_CAPDR;
      TAP_CAPDR:   nxt = Tms ? TAP_EX1DR : TAP_SHDR;
      TAP_SHDR:    nxt = Tms ? TAP_EX1DR : TAP_SHDR;
      TAP_EX1DR:   nxt = Tms ? TAP_UPDDR : TAP_PAUSEDR;
      TAP_PAUSEDR: nxt = Tms ? TAP_EX2DR : TAP_PAUSEDR;
      TAP_EX2DR:   nxt = Tms ? TAP_UPDDR : TAP_SHDR;
      TAP_UPDDR:   nxt = Tms ? TAP_SELDR : TAP_RTI;
      TAP_SELIR:   nxt = Tms ? TAP_TLR   : TAP_CAPIR;
      TAP_CAPIR:   nxt = Tms ? TAP_EX1IR : TAP_SHIR;
      TAP_SHIR:    nxt = Tms ? TAP_EX1IR : TAP_SHIR;
      TAP_EX1IR:   nxt = Tms ? TAP_UPDIR : TAP_PAUSEIR;
      TAP_PAUSEIR: nxt = Tms ? TAP_EX2IR : TAP_PAUSEIR;
      TAP_EX2IR:   nxt = Tms ? TAP_UPDIR : TAP_SHIR;
      TAP_UPDIR:   nxt = Tms ? TAP_SELDR : TAP_RTI;
      default:     nxt = TAP_TLR;
    endcase
  end

endmodule

// File: rtl/jtag_scan_controller.sv
// JTAG scan controller: accepts IR/DR scan, TAP reset and idle-run commands,
// sequences Tms/Tdi one bit per clk (one TCK), captures Tdo LSB first and
// returns it through a valid/ready response port.
// Optional feature: define JTAG_TRST_PULSE_EN to pull Trst low during the
// five Tms=1 cycles of every TAP reset sequence; otherwise Trst is tied high.
module jtag_scan_controller
  import JtagGlobalPkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [5:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        Tms,
  output logic        Tdi,
  output logic        Trst,
  input  logic        Tdo,
  output logic        busy,
  output logic [3:0]  tap_state
);

  localparam logic [5:0] LEN_CAP  = 6'(MAX_LEN);
  // Counter value of the single Tms=0 cycle that closes a TAP reset.
  localparam logic [5:0] RST_LAST = 6'(RST_TMS_CYCLES);

  ctrl_state_e state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  cmd_type_e   op_q;
  logic [5:0]  len_q;
  logic [31:0] data_q;
  logic [31:0] rsp_q;
  logic        rst_rsp_q;    // current TAP reset came from a command and owes a response
  logic [3:0]  tap_q, tap_d;

  cmd_type_e   cmd_op;
  logic [5:0]  len_eff;
  logic [5:0]  pre_last;
  logic [5:0]  last_idx;
  logic        accept;
  logic        capture;
  logic        is_scan;

  assign cmd_op   = cmd_type_e'(cmd_type);
  // Scan lengths clamp to MAX_LEN; an idle run counts cycles and is not clamped.
  assign len_eff  = (cmd_op == CMD_IDLE_RUN || cmd_len <= LEN_CAP) ? cmd_len : LEN_CAP;
  assign pre_last = (op_q == CMD_IR) ? 6'(IR_PRE_LEN - 1) : 6'(DR_PRE_LEN - 1);
  assign last_idx = len_q - 6'd1;
  assign is_scan  = (op_q == CMD_IR) || (op_q == CMD_DR);
  assign accept   = cmd_valid & cmd_ready;

  assign busy      = (state_q != IDLE);
  assign rsp_data  = rsp_q;
  assign tap_state = tap_q;

`ifdef JTAG_TRST_PULSE_EN
  // Trst pulses low with the Tms=1 run of a TAP reset, but stays high while
  // the controller itself is held in reset.
  assign Trst = ~((state_q == INIT_RST) && (cnt_q < RST_LAST) && !reset);
`else
  assign Trst = 1'b1;
`endif

  // Controller state and cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (reset) begin
      state_q <= INIT_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and TAP/handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    Tms       = 1'b0;
    Tdi       = 1'b0;
    capture   = 1'b0;
    case (state_q)
      INIT_RST: begin
        Tms   = (cnt_q < RST_LAST);
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = rst_rsp_q ? RESP : IDLE;
        end
      end
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cnt_d = '0;
          case (cmd_op)
            CMD_TAP_RST:  state_d = INIT_RST;
            CMD_IDLE_RUN: state_d = (cmd_len == 6'd0) ? RESP : SHIFT;
            default:      state_d = (len_eff == 6'd0) ? RESP : GOTO_SHIFT;
          endcase
        end
      end
      GOTO_SHIFT: begin
        Tms   = (op_q == CMD_IR) ? IR_TMS_PRE[cnt_q[1:0]] : DR_TMS_PRE[cnt_q[1:0]];
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == pre_last) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Idle runs reuse this state with Tms and Tdi held low.
        if (is_scan) begin
          Tms     = (cnt_q == last_idx);
          Tdi     = data_q[cnt_q[4:0]];
          capture = 1'b1;
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == last_idx) begin
          cnt_d   = '0;
          state_d = is_scan ? EXIT : RESP;
        end
      end
      EXIT: begin
        // Exit1 -> Update (Tms=1), Update -> Run-Test/Idle (Tms=0).
        Tms   = (cnt_q == 6'd0);
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd1) begin
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = INIT_RST;
    endcase
  end

  // Command capture and Tdo sampling; a new accept clears stale response bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= CMD_IR;
      len_q     <= '0;
      data_q    <= '0;
      rsp_q     <= '0;
      rst_rsp_q <= 1'b0;
    end else if (accept) begin
      op_q      <= cmd_op;
      len_q     <= len_eff;
      data_q    <= cmd_data;
      rsp_q     <= '0;
      rst_rsp_q <= (cmd_op == CMD_TAP_RST);
    end else if (capture) begin
      rsp_q[cnt_q[4:0]] <= Tdo;
    end
  end

  // Tracked TAP state follows the Tms driven in each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tap_q <= TAP_TLR;
    else       tap_q <= tap_d;
  end

  jtag_tap_tracker u_tap_tracker (
    .Tms        (Tms),
    .state      (tap_q),
    .next_state (tap_d)
  );

endmodule

// File: tb/tb_jtag_scan_controller.sv
// Self-checking bench for jtag_scan_controller: a scoreboard of expected
// response data and latency is filled when each command is issued and
// drained when the response appears; Tms/Tdi/Trst traces are compared
// against sequences built from the command alone.
module tb_jtag_scan_controller;

  localparam logic [3:0] TAP_TLR_V  = 4'hF;
  localparam logic [3:0] TAP_RTI_V  = 4'hC;
  localparam logic [3:0] TAP_SHDR_V = 4'h2;
  localparam logic [3:0] TAP_SHIR_V = 4'hA;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = 2'b00;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        Tms, Tdi, Trst, Tdo;
  logic        busy;
  logic [3:0]  tap_state;

  // Tdo source: 0 loopback of Tdi, 1 constant one, 2 constant zero, 3 inverted Tdi.
  logic [1:0]  tdo_sel = 2'd0;
  assign Tdo = (tdo_sel == 2'd0) ? Tdi :
               (tdo_sel == 2'd1) ? 1'b1 :
               (tdo_sel == 2'd2) ? 1'b0 : ~Tdi;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_data_q[$];
  int          exp_lat_q[$];

  always #5 clk = ~clk;

  jtag_scan_controller dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .Tms       (Tms),
    .Tdi       (Tdi),
    .Trst      (Trst),
    .Tdo       (Tdo),
    .busy      (busy),
    .tap_state (tap_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Apply reset at a negedge, check reset outputs, release, then follow the
  // INIT_RST sequence (5x Tms=1, 1x Tms=0) into IDLE.
  task automatic do_reset(input string tag);
    logic [5:0] tms_tr;
    logic [5:0] trst_tr;
    logic [5:0] exp_trst;
`ifdef JTAG_TRST_PULSE_EN
    exp_trst = 6'b100000;
`else
    exp_trst = 6'b111111;
`endif
    @(negedge clk);
    reset = 1'b1;
    #1;
    check({tag, "_rst_ctl"}, {Tms, Tdi, Trst, cmd_ready, rsp_valid, busy}, 6'b101001);
    check({tag, "_rst_data"}, rsp_data, 0);
    check({tag, "_rst_tap"}, tap_state, TAP_TLR_V);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    tms_tr[0]  = Tms;
    trst_tr[0] = Trst;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      tms_tr[i]  = Tms;
      trst_tr[i] = Trst;
    end
    check({tag, "_init_tms"}, tms_tr, 6'b011111);
    check({tag, "_init_trst"}, trst_tr, exp_trst);
    @(negedge clk);
    check({tag, "_init_idle"}, {cmd_ready, busy, rsp_valid}, 3'b100);
    check({tag, "_init_tap"}, tap_state, TAP_RTI_V);
  endtask

  // Issue one command, record TAP activity until the response, compare it
  // against the scoreboard, optionally hold rsp_ready low, then consume it.
  task automatic run_cmd(input logic [1:0] typ, input logic [5:0] len, input logic [31:0] data,
                         input logic [1:0] tsel, input int hold, input string tag);
    int          n, p, k, lat, shift_start;
    logic [31:0] mask, exp_rsp;
    logic [63:0] et, ed, er, gt, gd, gr;
    logic [3:0]  tap_sh;
    logic [31:0] got_data;
    int          got_lat;

    n           = (len > 6'd32) ? 32 : int'(len);
    mask        = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    et          = '0;
    ed          = '0;
    er          = '0;
    p           = 0;
    shift_start = -1;
    exp_rsp     = '0;
    tap_sh      = 4'h0;

    if (typ == 2'b00 || typ == 2'b01) begin
      if (n > 0) begin
        if (typ == 2'b00) begin
          et[0] = 1'b1; et[1] = 1'b1; et[2] = 1'b0; et[3] = 1'b0; p = 4;
        end else begin
          et[0] = 1'b1; et[1] = 1'b0; et[2] = 1'b0; p = 3;
        end
        shift_start = p;
        for (int i = 0; i < n; i++) begin
          ed[p] = data[i];
          et[p] = (i == n - 1);
          p++;
        end
        et[p] = 1'b1; p++;
        et[p] = 1'b0; p++;
        case (tsel)
          2'd0:    exp_rsp = data & mask;
          2'd1:    exp_rsp = mask;
          2'd2:    exp_rsp = 32'd0;
          default: exp_rsp = ~data & mask;
        endcase
      end
    end else if (typ == 2'b10) begin
      for (int i = 0; i < 5; i++) begin
        et[p] = 1'b1; p++;
      end
      et[p] = 1'b0; p++;
    end else begin
      p = int'(len);
    end
    lat = p + 1;
    for (int i = 0; i < p; i++) er[i] = 1'b1;
`ifdef JTAG_TRST_PULSE_EN
    if (typ == 2'b10) er[4:0] = 5'b00000;
`endif
    exp_data_q.push_back(exp_rsp);
    exp_lat_q.push_back(lat);

    tdo_sel   = tsel;
    cmd_type  = typ;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ready"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;

    gt = '0; gd = '0; gr = '0;
    k = 1;
    while (!rsp_valid && k < 100) begin
      if (k <= 64) begin
        gt[k-1] = Tms;
        gd[k-1] = Tdi;
        gr[k-1] = Trst;
      end
      if (k - 1 == shift_start) tap_sh = tap_state;
      @(negedge clk);
      k++;
    end

    got_lat  = rsp_valid ? k : -1;
    got_data = rsp_data;
    check({tag, "_latency"}, 64'(got_lat), 64'(exp_lat_q.pop_front()));
    check({tag, "_rsp_data"}, got_data, exp_data_q.pop_front());
    check({tag, "_tms_trace"}, gt, et);
    check({tag, "_tdi_trace"}, gd, ed);
    check({tag, "_trst_trace"}, gr, er);
    check({tag, "_resp_tap_tms"}, {tap_state, Tms, busy}, {TAP_RTI_V, 1'b0, 1'b1});
    if (shift_start >= 0)
      check({tag, "_shift_tap"}, tap_sh, (typ == 2'b00) ? TAP_SHIR_V : TAP_SHDR_V);

    // A second command is offered while the response is stalled; it must wait.
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      @(negedge clk);
      check({tag, "_hold"}, {rsp_valid, cmd_ready, rsp_data}, {1'b1, 1'b0, got_data});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_consumed"}, {rsp_valid, cmd_ready, busy}, 3'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rnd;
    rnd = $urandom();

    do_reset("por");

    run_cmd(2'b01, 6'd8,  32'h0000_00A5, 2'd0, 0,  "dr8_loop");
    run_cmd(2'b00, 6'd4,  32'h0000_0003, 2'd1, 0,  "ir4_one");
    run_cmd(2'b01, 6'd40, 32'hDEAD_BEEF, 2'd3, 0,  "dr40_clamp");
    run_cmd(2'b01, 6'd0,  32'hFFFF_FFFF, 2'd1, 0,  "dr0");
    run_cmd(2'b00, 6'd0,  32'h1234_5678, 2'd0, 0,  "ir0");
    run_cmd(2'b00, 6'd1,  32'h0000_0001, 2'd0, 0,  "ir1");
    run_cmd(2'b01, 6'd32, 32'h1234_5678, 2'd0, 0,  "dr32");
    run_cmd(2'b01, 6'd13, rnd,           2'd1, 0,  "dr13_rnd");
    run_cmd(2'b01, 6'd5,  32'h0000_0015, 2'd0, 10, "dr5_hold");
    run_cmd(2'b11, 6'd0,  32'h0,         2'd0, 0,  "idle0_waiter");
    run_cmd(2'b10, 6'd0,  32'h0,         2'd0, 0,  "tap_rst");
    run_cmd(2'b11, 6'd3,  32'hFFFF_FFFF, 2'd0, 0,  "idle3");
    run_cmd(2'b00, 6'd6,  32'h0000_002A, 2'd2, 0,  "ir6_zero");

    // Abort a DR scan in the middle of its shift phase.
    tdo_sel   = 2'd1;
    cmd_type  = 2'b01;
    cmd_len   = 6'd16;
    cmd_data  = 32'h0000_BEEF;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_pre_tap", tap_state, TAP_SHDR_V);
    do_reset("abort");

    run_cmd(2'b01, 6'd8, 32'h0000_003C, 2'd0, 0, "post_abort_dr8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
